// File: rtl/eth_rx_fcs_check_pkg.sv
// Shared constants and types for the receive-side Ethernet FCS checker and
// the byte-wise CRC-32 engine it shares with the transmit generator.
package eth_rx_fcs_check_pkg;

  localparam int datalen = 8;
  localparam int crc_len = 32;
  localparam int len_w   = 11;

  localparam logic [crc_len-1:0] crc_poly    = 32'h04C11DB7;
  localparam logic [crc_len-1:0] crc_init    = 32'hFFFFFFFF;
  localparam logic [crc_len-1:0] crc_residue = 32'hC704DD7B;

  localparam int eth_min_len = 64;
  localparam int eth_max_len = 1518;

  typedef enum logic [1:0] {
    IDLE,
    FILL,
    PASS
  } rx_state_t;

endpackage

// File: rtl/eth_rx_fcs_check_crc32_byte_next.sv
// One byte step of the Ethernet CRC-32: reflect the byte into the top of the
// accumulator, then run eight MSB-first polynomial shifts.
module crc32_byte_next
  import eth_rx_fcs_check_pkg::*;
(
  input  logic [crc_len-1:0] crc_in,
  input  logic [datalen-1:0] data,
  output logic [crc_len-1:0] crc_out
);

  logic [crc_len-1:0] c;

  always_comb begin
    // NOTE: blocking assignments are deliberate here; each loop pass reads
    // the value the previous pass just wrote, unrolling into a shift chain.
    c = crc_in;
    for (int b = 0; b < datalen; b++) begin
      c[crc_len-1-b] = crc_in[crc_len-1-b] ^ data[b];
    end
    for (int i = 0; i < datalen; i++) begin
      c = c[crc_len-1] ? ({c[crc_len-2:0], 1'b0} ^ crc_poly)
                       : {c[crc_len-2:0], 1'b0};
    end
    crc_out = c;
  end

endmodule

// File: rtl/eth_rx_fcs_check.sv
// Ethernet RX FCS checker/stripper: forwards the frame minus its 4-byte FCS
// and reports CRC and length status once per frame.
module eth_rx_fcs_check
  import eth_rx_fcs_check_pkg::*;
#(
  parameter int MIN_LEN = eth_min_len,
  parameter int MAX_LEN = eth_max_len
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [datalen-1:0] s_data,
  input  logic               s_valid,
  input  logic               s_last,
  output logic [datalen-1:0] m_data,
  output logic               m_valid,
  output logic               m_last,
  output logic               stat_valid,
  output logic               stat_crc_ok,
  output logic               stat_len_err,
  output logic [len_w-1:0]   stat_len
);

  rx_state_t state_q, state_d;
  logic [1:0] fill_q, fill_d;

  logic [3:0][datalen-1:0] buf_q, buf_d;
  logic [crc_len-1:0]      crc_q, crc_d, crc_base, crc_next;
  logic [len_w-1:0]        len_q, len_d, len_base, len_next;

  logic [datalen-1:0] m_data_q, m_data_d;
  logic               m_valid_q, m_valid_d;
  logic               m_last_q, m_last_d;
  logic               stat_valid_q, stat_valid_d;
  logic               stat_crc_ok_q, stat_crc_ok_d;
  logic               stat_len_err_q, stat_len_err_d;
  logic [len_w-1:0]   stat_len_q, stat_len_d;

  logic emit;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      fill_q  <= 2'd0;
    end else begin
      state_q <= state_d;
      fill_q  <= fill_d;
    end
  end

  // FILL counts held bytes 1..3; the fourth byte makes the buffer full.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path
    // leaves it unassigned, which would otherwise infer a latch.
    state_d = state_q;
    fill_d  = fill_q;
    if (s_valid) begin
      case (state_q)
        IDLE: begin
          if (!s_last) begin
            state_d = FILL;
            fill_d  = 2'd1;
          end
        end
        FILL: begin
          if (s_last)              state_d = IDLE;
          else if (fill_q == 2'd3) state_d = PASS;
          else                     fill_d  = fill_q + 2'd1;
        end
        PASS: begin
          if (s_last) state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // A frame's first byte starts from the init value, never the stale register.
  assign crc_base = (state_q == IDLE) ? crc_init : crc_q;
  assign len_base = (state_q == IDLE) ? '0 : len_q;
  assign len_next = (&len_base) ? len_base : len_base + len_w'(1);

  crc32_byte_next u_crc (
    .crc_in  (crc_base),
    .data    (s_data),
    .crc_out (crc_next)
  );

  always_comb begin
    emit           = s_valid && (state_q == PASS);
    buf_d          = s_valid ? {buf_q[2:0], s_data} : buf_q;
    crc_d          = s_valid ? crc_next : crc_q;
    len_d          = s_valid ? len_next : len_q;
    m_valid_d      = emit;
    m_last_d       = emit && s_last;
    m_data_d       = emit ? buf_q[3] : m_data_q;
    stat_valid_d   = s_valid && s_last;
    stat_crc_ok_d  = stat_crc_ok_q;
    stat_len_err_d = stat_len_err_q;
    stat_len_d     = stat_len_q;
    if (stat_valid_d) begin
      stat_crc_ok_d  = (crc_next == crc_residue);
      stat_len_err_d = (int'(len_next) < MIN_LEN) || (int'(len_next) > MAX_LEN);
      stat_len_d     = len_next;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      // NOTE: the 4-byte strip buffer is cleared on reset so an aborted
      // frame leaves nothing behind; only four bytes, so the cost is trivial.
      buf_q          <= '0;
      crc_q          <= crc_init;
      len_q          <= '0;
      m_data_q       <= '0;
      m_valid_q      <= 1'b0;
      m_last_q       <= 1'b0;
      stat_valid_q   <= 1'b0;
      stat_crc_ok_q  <= 1'b0;
      stat_len_err_q <= 1'b0;
      stat_len_q     <= '0;
    end else begin
      buf_q          <= buf_d;
      crc_q          <= crc_d;
      len_q          <= len_d;
      m_data_q       <= m_data_d;
      m_valid_q      <= m_valid_d;
      m_last_q       <= m_last_d;
      stat_valid_q   <= stat_valid_d;
      stat_crc_ok_q  <= stat_crc_ok_d;
      stat_len_err_q <= stat_len_err_d;
      stat_len_q     <= stat_len_d;
    end
  end

  assign m_data       = m_data_q;
  assign m_valid      = m_valid_q;
  assign m_last       = m_last_q;
  assign stat_valid   = stat_valid_q;
  assign stat_crc_ok  = stat_crc_ok_q;
  assign stat_len_err = stat_len_err_q;
  assign stat_len     = stat_len_q;

endmodule

// File: doc/eth_rx_fcs_check.md
# eth_rx_fcs_check

Receive-side Ethernet FCS checker and stripper, the counterpart of the transmit CRC-32 generator. It consumes the byte stream from the RX MAC front end, which includes the 4-byte FCS and has no backpressure. It forwards the frame with the FCS removed, and reports one status word per frame: CRC pass/fail, length and length error.

## Interface
Parameters:
- `MIN_LEN`, 64: minimum legal frame length in bytes, FCS included.
- `MAX_LEN`, 1518: maximum legal frame length in bytes, FCS included.

Ports:
- `clk`  in  1  single clock; all logic on its rising edge.
- `rst`  in  1  reset, synchronous and active-low.
- `s_data`  in  8 (`global::datalen`)  received byte.
- `s_valid`  in  1  `s_data` valid this cycle; gaps allowed mid-frame.
- `s_last`  in  1  qualifies the final byte of the frame (last FCS byte).
- `m_data`  out  8  payload byte, FCS stripped.
- `m_valid`  out  1  `m_data` valid.
- `m_last`  out  1  final payload byte.
- `stat_valid`  out  1  one-cycle pulse; status below is valid.
- `stat_crc_ok`  out  1  residue matched.
- `stat_len_err`  out  1  length < `MIN_LEN` or > `MAX_LEN`.
- `stat_len`  out  11  total bytes received, FCS included; saturates at 2047.

## Operation
- **CRC engine:** byte-wise CRC-32, identical to the TX generator.
  - Each accepted byte is bit-reflected, XORed into bits [31:24] of the accumulator, then shifted 8 times MSB-first with polynomial `global::crc_poly` (32'h04C11DB7).
  - Accumulator initial value is all ones. The first byte of each frame uses the init value, not the stale register.
- **Check:** computed over all bytes including FCS. After the `s_last` byte, raw accumulator == `global::crc_residue` (32'hC704DD7B) ⇒ `stat_crc_ok` = 1. Equivalently, the complemented, reflected value is 32'h2144DF1C.
- **Strip:** a 4-entry byte shift buffer.
  - Each accepted byte pushes in.
  - Once 4 bytes are held, each further accepted byte causes the oldest byte to be emitted.
  - The 4 bytes left at `s_last` are the FCS and are discarded.
- **State machine:**
  - IDLE: waits for `s_valid`. The first byte loads the buffer and the CRC, and the state moves to FILL. If that byte also has `s_last`, the frame is complete and the state stays in IDLE.
  - FILL: counts buffer occupancy 1–3. The 4th byte moves the state to PASS. `s_last` returns the state to IDLE.
  - PASS: every accepted byte emits one output byte. `s_last` returns the state to IDLE.
- **Short frames (≤4 bytes):** no `m_valid` ever. A status pulse is still generated: `stat_len_err` = 1 (for `MIN_LEN` ≥ 5) and `stat_crc_ok` = CRC result.
- **Errors do not suppress data.** Payload is always forwarded; downstream discards the frame on bad status.
- **Back-to-back frames:** a new frame's first byte may arrive the cycle after `s_last`. The buffer, CRC and counter restart cleanly.
- **Reset:** reset mid-frame discards the frame with no `m_last` and no `stat_valid`. On reset the state returns to IDLE and the buffer is emptied.
- **Reset values:** `m_data` = 0, `m_valid` = `m_last` = 0, `stat_valid` = 0, `stat_crc_ok` = 0, `stat_len_err` = 0, `stat_len` = 0.

## Timing
- All outputs are registered.
- Input byte k+4 accepted in cycle t ⇒ payload byte k on `m_data` with `m_valid` in cycle t+1.
- `s_last` in cycle t ⇒ in cycle t+1:
  - `m_last` = 1, with the final payload byte, if payload ≥ 1.
  - `stat_valid` = 1 in the same cycle.
- `stat_crc_ok`, `stat_len_err` and `stat_len` hold until the next `stat_valid`.
- `m_valid` is high for exactly one cycle per output byte. Input gaps produce output gaps.
- `s_last` without `s_valid` is ignored.

## Structure
- **Package `global`:**
  - Already provides `datalen`, `crc_len`, `crc_poly`.
  - Adds `crc_residue` = 32'hC704DD7B, `eth_min_len` = 64, `eth_max_len` = 1518 (defaults for the parameters).
  - Adds an `rx_state_t` enum: IDLE, FILL, PASS.
- **Sub-module `crc32_byte_next`:** combinational, (crc_in[31:0], data[7:0]) → crc_out[31:0]. It performs the reflect-in and 8 shift steps, and is shared with the TX generator.

## Test plan
1. `MIN_LEN` = 1. Input 31 32 33 34 35 36 37 38 39 26 39 F4 CB, with `s_last` on CB ⇒
   - `m_data` 31…39;
   - `m_last` on 39;
   - `stat_crc_ok` = 1, `stat_len` = 13, `stat_len_err` = 0.
2. Same frame with the last byte CA ⇒ identical `m_data`, `stat_crc_ok` = 0.
3. Default parameters. 60-byte frame plus model-generated FCS (64 bytes) ⇒ 60 output bytes, `crc_ok` = 1, `len_err` = 0. A 63-byte frame ⇒ `len_err` = 1. A 1519-byte frame ⇒ `len_err` = 1.
4. 3-byte frame AA BB CC ⇒ no `m_valid`; `stat_valid` pulse with `stat_len` = 3 and `len_err` = 1.
5. Frame 1 from item 1 sent twice back-to-back, with random `s_valid` gaps in the second ⇒ both frames pass with `crc_ok` = 1, and output bytes are ordered with no duplicates.
6. Assert reset (`rst` = 0) for 1 cycle after byte 7 of a frame, then send frame 1 ⇒ no status for the aborted frame; frame 1 checks good.
